tlb_fill_ctrl: RTL and testbench
================================

Name: tlb_fill_ctrl

Overview:
- Sequences writes into the TLB entry RAM.
- Accepts a fill request (a PTE from the hardware page-table walker) and selects a victim entry: first invalid entry, otherwise pseudo-LRU.
- Drives one-hot WriteEnables for exactly one cycle and tracks per-entry valid bits.
- Applies sfence.vma flushes, honouring the global (G) bit of each entry.

Parameters:
- TLB_ENTRIES, 8, number of TLB entries; power of two, at least 2.
- XLEN, 64, PTE width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- FillValid  in  1  walker presents a PTE to install
- FillReady  out  1  controller can accept a fill this cycle
- FillPTE  in  XLEN  PTE to install
- Flush  in  1  sfence.vma request, single-cycle effect
- FlushGlobal  in  1  1 = clear all entries; 0 = keep entries with G=1
- HitValid  in  1  translation hit this cycle; used for replacement update
- Matches  in  TLB_ENTRIES  one-hot CAM match vector
- PTE_Gs  in  TLB_ENTRIES  per-entry G bits read back from the entry RAM
- WriteEnables  out  TLB_ENTRIES  one-hot entry write strobe
- PTEOut  out  XLEN  registered PTE driven to the RAM write data
- Valids  out  TLB_ENTRIES  per-entry valid bits
- FillDone  out  1  one-cycle pulse when the fill completes
- Busy  out  1  FSM not in IDLE

Behaviour:
- Reset values (reset=0 at a clock edge):
  - FSM goes to IDLE.
  - Valids=0, WriteEnables=0, FillDone=0, PTEOut=0, PLRU tree=0, round-robin counter=0.
  - Reset takes effect from any state and aborts an in-flight fill.
- FSM states are IDLE, WRITE and DONE.
- IDLE:
  - FillReady = !Flush.
  - On FillValid && FillReady: latch FillPTE into PTEOut and latch the victim index, then go to WRITE.
  - Victim = lowest-index entry with Valids=0 if any exists; otherwise the replacement policy's choice.
- WRITE:
  - WriteEnables = onehot(victim) for this single cycle.
  - At the clock edge: Valids[victim] is set and the replacement state is updated as an access to the victim.
  - Next state is DONE.
- DONE: FillDone=1 for one cycle, then go to IDLE.
- FillReady is 0 in WRITE and DONE. Busy = (state != IDLE).
- Latency: fill accepted at cycle t → WriteEnables at t+1 → FillDone at t+2 → FillReady high again at t+3.
- Flush:
  - At the clock edge, Valids[i] is cleared for every i where FlushGlobal || !PTE_Gs[i].
  - Flush does not alter the replacement state.
- Flush in IDLE: the fill is not accepted that cycle.
- Flush in WRITE:
  - WriteEnables is forced to 0 and the write is aborted.
  - The victim's valid bit is not set.
  - FSM goes to IDLE with no FillDone.
  - The walker must re-request.
- Flush in DONE: FillDone is still pulsed, and the clear rule applies using the current PTE_Gs.
- Hit update:
  - When HitValid and (Matches & Valids) is nonzero, the replacement state is updated as an access to that entry.
  - A zero match vector causes no update.
  - Matches is one-hot or zero; other values are undefined behaviour.
- Hit and fill update in the same cycle: the hit update is applied first, then the fill update, so the fill wins on shared tree nodes.
- PLRU tree:
  - TLB_ENTRIES-1 bits; node 0 is the root; children of node n are 2n+1 and 2n+2.
  - Node bit 0 means the victim is in the lower-index half; 1 means the upper-index half.
  - An access sets each node on its path to point away from the accessed half.

Optional Feature:
- Macro: TLB_PLRU_EN.
- Defined: the victim for a full TLB comes from the tree-PLRU described above.
- Undefined:
  - The tree is not built.
  - The victim for a full TLB is a log2(TLB_ENTRIES)-bit round-robin counter, incremented (with wrap) on each completed WRITE into a full TLB.
  - HitValid and Matches are ignored.
  - The invalid-first rule still applies.

Test Plan:
1. Reset, then 8 back-to-back fills (TLB_ENTRIES=8) → WriteEnables = 0x01, 0x02, … 0x80, one per fill at t+1; FillDone at t+2; Valids=0xFF at the end.
2. TLB_PLRU_EN defined; after test 1, one more fill → victim entry 0 (WriteEnables=0x01). Then HitValid with Matches=0x01, then a fill → WriteEnables=0x10.
3. TLB_PLRU_EN undefined; after test 1, two fills → WriteEnables 0x01 then 0x02; a HitValid with Matches=0x01 in between does not change the order.
4. Valids=0xFF, PTE_Gs=0x0F, Flush=1 with FlushGlobal=0 → Valids=0x0F next cycle; the next fill writes entry 4 (WriteEnables=0x10). Flush with FlushGlobal=1 → Valids=0x00.
5. Flush asserted during the WRITE cycle → WriteEnables=0 that cycle, the victim's valid bit stays 0, no FillDone, FillReady=1 next cycle.
6. reset=0 while in DONE → next cycle FillDone=0, Valids=0, WriteEnables=0, FillReady=1 once reset=1.

Source files
------------

// File: rtl/tlb_fill_ctrl.sv
// TLB fill sequencer. It picks the first invalid entry as the victim, otherwise the replacement policy's choice.
// It also strobes the entry RAM and tracks valid bits under sfence.vma. Define TLB_PLRU_EN for tree-PLRU; otherwise a round-robin counter is used.
module tlb_fill_ctrl #(
  parameter int TLB_ENTRIES = 8,
  parameter int XLEN        = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   FillValid,
  output logic                   FillReady,
  input  logic [XLEN-1:0]        FillPTE,
  input  logic                   Flush,
  input  logic                   FlushGlobal,
  input  logic                   HitValid,
  input  logic [TLB_ENTRIES-1:0] Matches,
  input  logic [TLB_ENTRIES-1:0] PTE_Gs,
  output logic [TLB_ENTRIES-1:0] WriteEnables,
  output logic [XLEN-1:0]        PTEOut,
  output logic [TLB_ENTRIES-1:0] Valids,
  output logic                   FillDone,
  output logic                   Busy
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                 state_q;
  logic [XLEN-1:0]        pte_q;
  logic [IDX_W-1:0]       victim_q, victim_d, policy_victim;
  logic [TLB_ENTRIES-1:0] valid_q, valid_d, flush_clr, victim_oh;
  logic                   accept, write_go, have_free;
  logic [IDX_W-1:0]       free_idx;

  assign accept    = (state_q == IDLE) && FillValid && !Flush;
  // A flush landing on the write cycle kills the strobe; the walker re-requests.
  assign write_go  = (state_q == WRITE) && !Flush;
  assign victim_oh = TLB_ENTRIES'(1) << victim_q;
  assign flush_clr = Flush ? (FlushGlobal ? '1 : ~PTE_Gs) : '0;

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
  end

  assign victim_d = have_free ? free_idx : policy_victim;
  assign valid_d  = (valid_q | (write_go ? victim_oh : '0)) & ~flush_clr;

`ifdef TLB_PLRU_EN
  logic [TLB_ENTRIES-2:0] plru_q, plru_d;
  logic [IDX_W-1:0]       hit_idx;
  logic                   hit_any;

  function automatic logic [TLB_ENTRIES-2:0] plru_touch(input logic [TLB_ENTRIES-2:0] t,
                                                        input logic [IDX_W-1:0] idx);
    logic [TLB_ENTRIES-2:0] r;
    logic [IDX_W-1:0]       n;
    r = t;
    n = '0;
    for (int l = 0; l < IDX_W; l++) begin
      r[n] = ~idx[IDX_W-1-l];
      n    = n + n + IDX_W'(1) + IDX_W'(idx[IDX_W-1-l]);
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] plru_pick(input logic [TLB_ENTRIES-2:0] t);
    logic [IDX_W-1:0] n, v;
    n = '0;
    v = '0;
    for (int l = 0; l < IDX_W; l++) begin
      v[IDX_W-1-l] = t[n];
      n            = n + n + IDX_W'(1) + IDX_W'(t[n]);
    end
    return v;
  endfunction

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (Matches[i] && valid_q[i]) hit_idx = IDX_W'(i);
    end
  end

  assign hit_any       = |(Matches & valid_q);
  assign policy_victim = plru_pick(plru_q);

  // Hit applied first so the fill owns any shared nodes.
  always_comb begin
    plru_d = plru_q;
    if (HitValid && hit_any) plru_d = plru_touch(plru_d, hit_idx);
    if (write_go)            plru_d = plru_touch(plru_d, victim_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) plru_q <= '0;
    else        plru_q <= plru_d;
  end
`else
  logic [IDX_W-1:0] rr_q;
  logic             full_q;
  logic             unused_hit;

  assign unused_hit    = HitValid ^ (^Matches);
  assign policy_victim = rr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q   <= '0;
      full_q <= 1'b0;
    end else begin
      if (accept)             full_q <= !have_free;
      if (write_go && full_q) rr_q   <= rr_q + IDX_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pte_q    <= '0;
      victim_q <= '0;
      valid_q  <= '0;
    end else begin
      valid_q <= valid_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            pte_q    <= FillPTE;
            victim_q <= victim_d;
            state_q  <= WRITE;
          end
        end
        WRITE:   state_q <= Flush ? IDLE : DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FillReady    = (state_q == IDLE) && !Flush;
  assign WriteEnables = write_go ? victim_oh : '0;
  assign PTEOut       = pte_q;
  assign Valids       = valid_q;
  assign FillDone     = (state_q == DONE);
  assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// Directed bench for tlb_fill_ctrl: fill sequencing, victim choice, flush and reset behaviour.
module tb_tlb_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        FillValid, FillReady, Flush, FlushGlobal, HitValid, FillDone, Busy;
  logic [63:0] FillPTE, PTEOut;
  logic [7:0]  Matches, PTE_Gs, WriteEnables, Valids;

  int n_vec = 0;
  int n_bad = 0;

  tlb_fill_ctrl #(.TLB_ENTRIES(8), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .FillValid(FillValid), .FillReady(FillReady),
    .FillPTE(FillPTE), .Flush(Flush), .FlushGlobal(FlushGlobal), .HitValid(HitValid),
    .Matches(Matches), .PTE_Gs(PTE_Gs), .WriteEnables(WriteEnables), .PTEOut(PTEOut),
    .Valids(Valids), .FillDone(FillDone), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full fill from IDLE; returns in IDLE one cycle after FillDone.
  task automatic do_fill(input string tag, input logic [63:0] pte, input logic [7:0] exp_we);
    FillValid = 1'b1;
    FillPTE   = pte;
    #1 chk({tag, ".ready"}, FillReady, 1'b1);
    tick();
    FillValid = 1'b0;
    #1;
    chk({tag, ".we"}, WriteEnables, exp_we);
    chk({tag, ".pte"}, PTEOut, pte);
    chk({tag, ".done_early"}, FillDone, 1'b0);
    tick();
    chk({tag, ".done"}, FillDone, 1'b1);
    chk({tag, ".rdy_done"}, FillReady, 1'b0);
    chk({tag, ".we_done"}, WriteEnables, 8'h00);
    tick();
    chk({tag, ".idle"}, FillReady, 1'b1);
    chk({tag, ".idle_busy"}, Busy, 1'b0);
  endtask

  initial begin
    reset = 1'b0; FillValid = 1'b0; FillPTE = '0; Flush = 1'b0; FlushGlobal = 1'b0;
    HitValid = 1'b0; Matches = '0; PTE_Gs = '0;
    tick(); tick();
    chk("rst.valids", Valids, 8'h00);
    chk("rst.we", WriteEnables, 8'h00);
    chk("rst.done", FillDone, 1'b0);
    chk("rst.pteout", PTEOut, 64'h0);
    chk("rst.busy", Busy, 1'b0);
    reset = 1'b1;
    tick();

    // Cold fills land in entries 0..7 in order.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] we;
      we = 8'h01 << i;
      do_fill($sformatf("cold%0d", i), 64'hA000_0000_0000_0000 | 64'(i), we);
    end
    chk("cold.valids", Valids, 8'hFF);

`ifdef TLB_PLRU_EN
    do_fill("plru.first", 64'hB1, 8'h01);
    HitValid = 1'b1; Matches = 8'h01;
    tick();
    HitValid = 1'b0; Matches = 8'h00;
    do_fill("plru.after_hit", 64'hB2, 8'h10);
`else
    do_fill("rr.first", 64'hB1, 8'h01);
    HitValid = 1'b1; Matches = 8'h01;
    tick();
    HitValid = 1'b0; Matches = 8'h00;
    do_fill("rr.second", 64'hB2, 8'h02);
`endif

    // Non-global flush keeps G entries and blocks the concurrent fill.
    PTE_Gs = 8'h0F; Flush = 1'b1; FlushGlobal = 1'b0; FillValid = 1'b1; FillPTE = 64'hC0;
    #1 chk("flush.ready", FillReady, 1'b0);
    tick();
    Flush = 1'b0; FillValid = 1'b0;
    #1;
    chk("flush.valids", Valids, 8'h0F);
    chk("flush.not_accepted", Busy, 1'b0);
    do_fill("flush.refill", 64'hC1, 8'h10);
    chk("flush.refill_valids", Valids, 8'h1F);
    Flush = 1'b1; FlushGlobal = 1'b1;
    tick();
    Flush = 1'b0; FlushGlobal = 1'b0;
    #1 chk("flushg.valids", Valids, 8'h00);

    // Flush on the WRITE cycle aborts the fill; entry 0 is global and survives.
    do_fill("abort.pre", 64'hD0, 8'h01);
    PTE_Gs = 8'h01;
    FillValid = 1'b1; FillPTE = 64'hD1;
    tick();
    FillValid = 1'b0; Flush = 1'b1;
    #1 chk("abort.we", WriteEnables, 8'h00);
    tick();
    Flush = 1'b0;
    #1;
    chk("abort.valids", Valids, 8'h01);
    chk("abort.done", FillDone, 1'b0);
    chk("abort.ready", FillReady, 1'b1);

    // Global flush on the DONE cycle still pulses FillDone.
    FillValid = 1'b1; FillPTE = 64'hE0;
    tick();
    FillValid = 1'b0;
    #1 chk("fdone.we", WriteEnables, 8'h02);
    tick();
    Flush = 1'b1; FlushGlobal = 1'b1;
    #1 chk("fdone.done", FillDone, 1'b1);
    tick();
    Flush = 1'b0; FlushGlobal = 1'b0;
    #1 chk("fdone.valids", Valids, 8'h00);

    // Reset while in DONE.
    FillValid = 1'b1; FillPTE = 64'hF0;
    tick();
    FillValid = 1'b0;
    tick();
    chk("rdone.in_done", FillDone, 1'b1);
    reset = 1'b0;
    tick();
    chk("rdone.done", FillDone, 1'b0);
    chk("rdone.valids", Valids, 8'h00);
    chk("rdone.we", WriteEnables, 8'h00);
    chk("rdone.pteout", PTEOut, 64'h0);
    reset = 1'b1;
    tick();
    chk("rdone.ready", FillReady, 1'b1);
    do_fill("rdone.refill", 64'hF1, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
